ship_mover: RTL and testbench
=============================

# ship_mover

Parametrised successor to the player-ship position controller. It turns the debounced left/right buttons into a saturating horizontal ship coordinate. Movement advances only on frame-rate enable ticks and supports auto-repeat: one immediate step on press, then repeated steps after a hold delay. Sits between the edge-detector/debouncer outputs and the display/collision logic, running in the 25 MHz pixel-clock domain.

## Interface
Parameters:
- X_WIDTH, 5, width of the position coordinate
- LEFT_LIMIT, 0, minimum position
- RIGHT_LIMIT, 19, maximum position
- RESET_POS, 5, position after reset
- STEP, 1, positions moved per step
- REPEAT_DELAY, 8, enable ticks from the first step to the first repeat step
- REPEAT_PERIOD, 2, enable ticks between repeat steps
- Legal values: LEFT_LIMIT <= RESET_POS <= RIGHT_LIMIT < 2^X_WIDTH; STEP >= 1; REPEAT_DELAY >= 1; REPEAT_PERIOD >= 1

Ports:
- i_clk_25MHz, in, 1, single clock; all logic is rising-edge
- i_reset, in, 1, asynchronous, active-low reset
- i_left_debounced, in, 1, left button level
- i_right_debounced, in, 1, right button level
- i_enable, in, 1, one-cycle frame tick; inputs are sampled and state advances only when this is high
- o_ship_x, out, X_WIDTH, registered ship position
- o_at_left, out, 1, registered; high iff o_ship_x == LEFT_LIMIT
- o_at_right, out, 1, registered; high iff o_ship_x == RIGHT_LIMIT
- o_moved, out, 1, one-cycle pulse; high for the cycle after a tick that changed o_ship_x

## Operation
- Decoded direction on each tick:
  - LEFT: left high, right low
  - RIGHT: right high, left low
  - NONE: both low or both high
- State machine states: IDLE, DELAY, REPEAT. A tick counter cnt of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) + 1 tracks ticks; a register holds the last direction.
- Every transition below happens only on a cycle where i_enable = 1. With i_enable = 0, all registers hold and o_moved = 0.
- Any state, direction NONE: go to IDLE, cnt <= 0, no step.
- IDLE, LEFT or RIGHT: step, store the direction, cnt <= 0, go to DELAY.
- DELAY or REPEAT, direction differs from the stored one: treat as a new press (step in the new direction, cnt <= 0, go to DELAY).
- DELAY, same direction:
  - if cnt == REPEAT_DELAY-1: step, cnt <= 0, go to REPEAT
  - otherwise cnt <= cnt+1
- REPEAT, same direction:
  - if cnt == REPEAT_PERIOD-1: step, cnt <= 0
  - otherwise cnt <= cnt+1
- Step arithmetic is done in X_WIDTH+1 bits, unsigned:
  - LEFT: if x < LEFT_LIMIT+STEP then x <= LEFT_LIMIT, else x <= x-STEP
  - RIGHT: if x+STEP > RIGHT_LIMIT then x <= RIGHT_LIMIT, else x <= x+STEP
  - No wrap-around under any parameter set.
- A step attempted at a limit leaves x unchanged and keeps o_moved = 0, but the state and cnt still advance as though the step happened.
- o_at_left and o_at_right are updated in the same cycle as o_ship_x, so they are always consistent with it.

## Timing
- Reset (i_reset = 0, asynchronous, regardless of clock):
  - o_ship_x = RESET_POS
  - o_at_left = (RESET_POS == LEFT_LIMIT)
  - o_at_right = (RESET_POS == RIGHT_LIMIT)
  - o_moved = 0, state IDLE, cnt 0, stored direction cleared
- Reset release: synchronous to the design; the first tick sampled afterwards behaves as from IDLE.
- Reset asserted mid-hold: the state is lost. A button still held after release counts as a fresh press and gives an immediate step on the next tick.
- Latency: o_ship_x, the limit flags and o_moved all change on the clock edge that samples the enable tick, and are visible one cycle after that tick.
- Step ticks for a held button, with the press first seen at tick 0: 0, REPEAT_DELAY, then REPEAT_DELAY + k·REPEAT_PERIOD for k = 1, 2, … With defaults: 0, 8, 10, 12, …
- Button changes between ticks are ignored; only the level present at a tick matters.

## Test plan
- Reset and limit flags: assert i_reset = 0 mid-run, including between clock edges -> o_ship_x = 5 immediately, o_moved = 0, o_at_left = 0, o_at_right = 0.
- Single tap: right high for one tick, then released -> o_ship_x goes 5 -> 6 with exactly one o_moved pulse; no further movement on later ticks.
- Auto-repeat: right held for 13 ticks starting at x = 5 -> steps at ticks 0, 8, 10, 12; o_ship_x = 9 at the end.
- Saturation with STEP = 3: start at x = 18, hold right -> x = 19, o_at_right = 1, no o_moved on later step ticks. Then hold left from x = 1 -> x = 0, o_at_left = 1.
- Both buttons or a direction change:
  - both held -> no movement and state returns to IDLE
  - right held for 5 ticks, then left -> immediate left step on the switching tick, next left step 8 ticks later
- Enable gating: toggle the buttons while i_enable = 0 for 100 cycles -> o_ship_x, cnt and o_moved unchanged.

Source files
------------

// File: rtl/ship_mover.sv
// ---------------------------------------------------------------------------
// ship_mover
//
// Purpose:
//   Converts the debounced left/right button levels into a saturating
//   horizontal ship coordinate.  The ship only moves on frame-rate enable
//   ticks.  A press gives one immediate step.  Holding the button then
//   auto-repeats: the first repeat step comes REPEAT_DELAY ticks after the
//   press, and later steps follow every REPEAT_PERIOD ticks.
//
// Parameters:
//   X_WIDTH       width of the position coordinate
//   LEFT_LIMIT    minimum position
//   RIGHT_LIMIT   maximum position
//   RESET_POS     position after reset
//   STEP          positions moved per step
//   REPEAT_DELAY  ticks from the first step to the first repeat step
//   REPEAT_PERIOD ticks between repeat steps
//
// Ports:
//   i_clk_25MHz        in   pixel clock, rising-edge logic only
//   i_reset            in   asynchronous, active-low reset
//   i_left_debounced   in   left button level
//   i_right_debounced  in   right button level
//   i_enable           in   one-cycle frame tick; the design samples and
//                           advances only when this is high
//   o_ship_x           out  registered ship position
//   o_at_left          out  registered, high iff o_ship_x == LEFT_LIMIT
//   o_at_right         out  registered, high iff o_ship_x == RIGHT_LIMIT
//   o_moved            out  one-cycle pulse after a tick that changed x
// ---------------------------------------------------------------------------
module ship_mover #(
    parameter int X_WIDTH       = 5,
    parameter int LEFT_LIMIT    = 0,
    parameter int RIGHT_LIMIT   = 19,
    parameter int RESET_POS     = 5,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 2
) (
    input  logic               i_clk_25MHz,
    input  logic               i_reset,
    input  logic               i_left_debounced,
    input  logic               i_right_debounced,
    input  logic               i_enable,
    output logic [X_WIDTH-1:0] o_ship_x,
    output logic               o_at_left,
    output logic               o_at_right,
    output logic               o_moved
);

    // The tick counter must hold values up to max(REPEAT_DELAY, REPEAT_PERIOD)-1.
    localparam int MAX_TICKS = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_WIDTH = $clog2(MAX_TICKS) + 1;

    // Limit comparisons use one extra bit so that x + STEP cannot wrap.
    // A step larger than the coordinate range always saturates, so STEP
    // is clamped to 2^X_WIDTH. This keeps every sum inside X_WIDTH+1 bits.
    localparam int XW1          = X_WIDTH + 1;
    localparam int POS_RANGE    = 1 << X_WIDTH;
    localparam int STEP_CLAMPED = (STEP > POS_RANGE) ? POS_RANGE : STEP;

    localparam logic [X_WIDTH:0]   LEFT_W  = XW1'(LEFT_LIMIT);
    localparam logic [X_WIDTH:0]   RIGHT_W = XW1'(RIGHT_LIMIT);
    localparam logic [X_WIDTH:0]   STEP_W  = XW1'(STEP_CLAMPED);

    localparam logic [X_WIDTH-1:0] LEFT_X  = X_WIDTH'(LEFT_LIMIT);
    localparam logic [X_WIDTH-1:0] RIGHT_X = X_WIDTH'(RIGHT_LIMIT);
    localparam logic [X_WIDTH-1:0] RESET_X = X_WIDTH'(RESET_POS);
    localparam logic [X_WIDTH-1:0] STEP_X  = X_WIDTH'(STEP_CLAMPED);

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t                 state;
    state_t                 next_state;
    dir_t                   dir;
    dir_t                   last_dir;
    dir_t                   next_dir;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   next_cnt;
    logic                   take_step;

    logic [X_WIDTH:0]       x_ext;
    logic [X_WIDTH-1:0]     left_target;
    logic [X_WIDTH-1:0]     right_target;
    logic [X_WIDTH-1:0]     step_target;

    // Decode the button pair. When both buttons are held, the moves cancel
    // and the result is the same as when neither is pressed.
    always_comb begin
        dir = DIR_NONE;
        if (i_left_debounced && !i_right_debounced) begin
            dir = DIR_LEFT;
        end else if (i_right_debounced && !i_left_debounced) begin
            dir = DIR_RIGHT;
        end
    end

    // Saturating step targets. The comparisons run in X_WIDTH+1 bits. When
    // the subtraction or addition branch is taken, the result is known to
    // lie inside [LEFT_LIMIT, RIGHT_LIMIT], so X_WIDTH bits hold it exactly.
    always_comb begin
        x_ext = {1'b0, o_ship_x};

        if (x_ext < LEFT_W + STEP_W) begin
            left_target = LEFT_X;
        end else begin
            left_target = o_ship_x - STEP_X;
        end

        if (x_ext + STEP_W > RIGHT_W) begin
            right_target = RIGHT_X;
        end else begin
            right_target = o_ship_x + STEP_X;
        end

        step_target = (dir == DIR_LEFT) ? left_target : right_target;
    end

    // Auto-repeat decision for the current tick. A change of direction while
    // a button is held counts as a brand-new press. The counter restarts and
    // the new direction gets its immediate step.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_dir   = last_dir;
        take_step  = 1'b0;

        if (dir == DIR_NONE) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else if (state == IDLE || dir != last_dir) begin
            take_step  = 1'b1;
            next_dir   = dir;
            next_cnt   = '0;
            next_state = DELAY;
        end else if (state == DELAY) begin
            if (cnt == DELAY_LAST) begin
                take_step  = 1'b1;
                next_cnt   = '0;
                next_state = REPEAT;
            end else begin
                next_cnt = cnt + CNT_ONE;
            end
        end else begin
            if (cnt == PERIOD_LAST) begin
                take_step = 1'b1;
                next_cnt  = '0;
            end else begin
                next_cnt = cnt + CNT_ONE;
            end
        end
    end

    // State, counter, stored direction and all outputs are registered together.
    // The limit flags are derived from the new position, so they are always
    // consistent with o_ship_x. A step attempted at a limit still advances
    // the state machine but leaves x and o_moved unchanged.
    always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_dir   <= DIR_NONE;
            o_ship_x   <= RESET_X;
            o_at_left  <= (RESET_X == LEFT_X);
            o_at_right <= (RESET_X == RIGHT_X);
            o_moved    <= 1'b0;
        end else begin
            o_moved <= 1'b0;
            if (i_enable) begin
                state    <= next_state;
                cnt      <= next_cnt;
                last_dir <= next_dir;
                if (take_step) begin
                    o_ship_x   <= step_target;
                    o_at_left  <= (step_target == LEFT_X);
                    o_at_right <= (step_target == RIGHT_X);
                    o_moved    <= (step_target != o_ship_x);
                end
            end
        end
    end

endmodule

// File: tb/tb_ship_mover.sv
// ---------------------------------------------------------------------------
// tb_ship_mover
//
// Directed bench for ship_mover. Instance dut_a uses the default parameters.
// Instance dut_b uses STEP = 3 and RESET_POS = 18, so it reaches both limits.
// Both instances share the clock, reset, enable and buttons.
// ---------------------------------------------------------------------------
module tb_ship_mover;

    logic       clk;
    logic       reset_n;
    logic       left_btn;
    logic       right_btn;
    logic       enable;

    logic [4:0] a_x;
    logic       a_at_left;
    logic       a_at_right;
    logic       a_moved;

    logic [4:0] b_x;
    logic       b_at_left;
    logic       b_at_right;
    logic       b_moved;

    int         checks;
    int         errors;

    ship_mover dut_a (
        .i_clk_25MHz       (clk),
        .i_reset           (reset_n),
        .i_left_debounced  (left_btn),
        .i_right_debounced (right_btn),
        .i_enable          (enable),
        .o_ship_x          (a_x),
        .o_at_left         (a_at_left),
        .o_at_right        (a_at_right),
        .o_moved           (a_moved)
    );

    ship_mover #(
        .STEP      (3),
        .RESET_POS (18)
    ) dut_b (
        .i_clk_25MHz       (clk),
        .i_reset           (reset_n),
        .i_left_debounced  (left_btn),
        .i_right_debounced (right_btn),
        .i_enable          (enable),
        .o_ship_x          (b_x),
        .o_at_left         (b_at_left),
        .o_at_right        (b_at_right),
        .o_moved           (b_moved)
    );

    // 25 MHz pixel clock.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Counts every comparison and reports the ones that disagree.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Raises enable for exactly one clock edge, with the given button levels.
    // Returns at the following falling edge. At that point the outputs
    // reflect the tick and o_moved still shows its pulse.
    task automatic applyStimulus(input logic l, input logic r);
        @(negedge clk);
        left_btn  = l;
        right_btn = r;
        enable    = 1'b1;
        @(negedge clk);
        enable    = 1'b0;
    endtask

    // Stops the run if the directed sequence ever fails to complete.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_left_x [21] = '{16, 16, 16, 16, 16, 16, 16, 16, 13, 13,
                                10, 10,  7,  7,  4,  4,  1,  1,  0,  0, 0};
        int prev_x;
        int moved_seen;
        int x_changes;
        logic [4:0] x_before;

        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        left_btn  = 1'b0;
        right_btn = 1'b0;
        enable    = 1'b0;

        // Power-on reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_a_x",        a_x,        5);
        checkOutput("rst_a_at_left",  a_at_left,  0);
        checkOutput("rst_a_at_right", a_at_right, 0);
        checkOutput("rst_a_moved",    a_moved,    0);
        checkOutput("rst_b_x",        b_x,        18);
        checkOutput("rst_b_at_right", b_at_right, 0);
        reset_n = 1'b1;

        // Single tap: one step, one pulse, then no further movement.
        applyStimulus(1'b0, 1'b1);
        checkOutput("tap_x",     a_x,     6);
        checkOutput("tap_moved", a_moved, 1);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("tap_after_x_%0d", t),     a_x,     6);
            checkOutput($sformatf("tap_after_moved_%0d", t), a_moved, 0);
        end

        // Reset asserted between clock edges takes effect at once.
        @(posedge clk);
        #7;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_x",        a_x,        5);
        checkOutput("async_rst_moved",    a_moved,    0);
        checkOutput("async_rst_at_left",  a_at_left,  0);
        checkOutput("async_rst_at_right", a_at_right, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Auto-repeat: right held for 13 ticks steps at ticks 0, 8, 10, 12.
        for (int t = 0; t < 13; t++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("rep_moved_t%0d", t), a_moved,
                        (t == 0 || t == 8 || t == 10 || t == 12) ? 1 : 0);
        end
        checkOutput("rep_final_x", a_x, 9);

        // Both buttons held: no move. A following right press is a fresh press.
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_x",     a_x,     9);
        checkOutput("both_moved", a_moved, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("after_both_x",     a_x,     10);
        checkOutput("after_both_moved", a_moved, 1);

        // Right held for 5 ticks in total, then switch to left.
        for (int t = 1; t < 5; t++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("chg_right_moved_t%0d", t), a_moved, 0);
        end
        checkOutput("chg_right_x", a_x, 10);
        applyStimulus(1'b1, 1'b0);
        checkOutput("chg_left_x",     a_x,     9);
        checkOutput("chg_left_moved", a_moved, 1);
        for (int t = 1; t < 8; t++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("chg_left_moved_t%0d", t), a_moved, 0);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("chg_left_t8_x",     a_x,     8);
        checkOutput("chg_left_t8_moved", a_moved, 1);

        // Enable low for 100 cycles while the buttons toggle: nothing moves.
        x_before   = a_x;
        moved_seen = 0;
        x_changes  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            left_btn  = i[0];
            right_btn = i[1];
            if (a_moved) moved_seen++;
            if (a_x != x_before) x_changes++;
        end
        checkOutput("gate_moved_cycles", moved_seen, 0);
        checkOutput("gate_x_changes",    x_changes,  0);

        // The repeat counter survived the gap: one idle tick, then a step.
        applyStimulus(1'b1, 1'b0);
        checkOutput("gate_resume1_x",     a_x,     8);
        checkOutput("gate_resume1_moved", a_moved, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("gate_resume2_x",     a_x,     7);
        checkOutput("gate_resume2_moved", a_moved, 1);

        // Reset during a hold: the still-held button acts as a fresh press.
        @(posedge clk);
        #5;
        reset_n = 1'b0;
        #1;
        checkOutput("hold_rst_x", a_x, 5);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("hold_rst_step_x",     a_x,     4);
        checkOutput("hold_rst_step_moved", a_moved, 1);

        // Saturation on dut_b (STEP = 3, starting at 18).
        @(negedge clk);
        reset_n   = 1'b0;
        left_btn  = 1'b0;
        right_btn = 1'b0;
        @(negedge clk);
        checkOutput("sat_rst_x", b_x, 18);
        reset_n = 1'b1;
        for (int t = 0; t < 13; t++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("sat_right_x_t%0d", t),     b_x,       19);
            checkOutput($sformatf("sat_right_moved_t%0d", t), b_moved,   (t == 0) ? 1 : 0);
            checkOutput($sformatf("sat_right_flag_t%0d", t),  b_at_right, 1);
        end
        prev_x = 19;
        for (int t = 0; t < 21; t++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("sat_left_x_t%0d", t),     b_x,       exp_left_x[t]);
            checkOutput($sformatf("sat_left_moved_t%0d", t), b_moved,   (exp_left_x[t] != prev_x) ? 1 : 0);
            checkOutput($sformatf("sat_left_flag_t%0d", t),  b_at_left, (exp_left_x[t] == 0) ? 1 : 0);
            checkOutput($sformatf("sat_left_rflag_t%0d", t), b_at_right, 0);
            prev_x = exp_left_x[t];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
